// File: rtl/arr_seq_pkg.sv
// Shared constants for the array load sequencer: controller mode codes,
// sequencer state encoding and default stream geometry.
package arr_seq_pkg;

  localparam logic [1:0] MODE_CFG = 2'b00;
  localparam logic [1:0] MODE_ACT = 2'b01;
  localparam logic [1:0] MODE_WGT = 2'b10;
  localparam logic [1:0] MODE_RUN = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CFG  = 3'd1,
    ST_ACT  = 3'd2,
    ST_WGT  = 3'd3,
    ST_RUN  = 3'd4,
    ST_FIN  = 3'd5
  } state_e;

  localparam int unsigned DEF_ACT_BYTES = 432;   // 3*3*3*16
  localparam int unsigned DEF_WGT_BYTES = 768;   // 3*16*16
  localparam int unsigned DEF_ACT_BASE  = 0;
  localparam int unsigned DEF_WGT_BASE  = 1024;
  localparam int unsigned DEF_AW        = 12;
  localparam int unsigned DEF_RUN_MAX   = 2048;
  localparam int unsigned CNT_W         = 10;    // byte counter, covers 768

endpackage

// File: rtl/arr_seq_rdgen.sv
// SRAM read-address generator. A load starts a burst of len_i consecutive
// reads at base_i; mem_re/mem_addr are registered, last_o flags the cycle
// presenting the final read of the burst.
//   clk, rst     : clock, synchronous active-high reset
//   load_i       : (re)start a burst; overrides any burst in flight
//   base_i/len_i : burst start address and read count (len_i >= 1)
//   mem_re_o     : read enable, mem_addr_o : read address
//   last_o       : current read is the last of the burst
module arr_seq_rdgen
  import arr_seq_pkg::*;
#(
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned LEN_W = CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [AW-1:0] base_i,
  input  logic [LEN_W-1:0] len_i,
  output logic          mem_re_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          last_o
);

  logic             re_q;
  logic [AW-1:0]    addr_q;
  logic [LEN_W-1:0] rem_q;   // reads remaining after the current one

  always_ff @(posedge clk) begin
    if (rst) begin
      re_q   <= 1'b0;
      addr_q <= '0;
      rem_q  <= '0;
    end else if (load_i) begin
      re_q   <= 1'b1;
      addr_q <= base_i;
      rem_q  <= len_i - LEN_W'(1);
    end else if (re_q) begin
      if (rem_q == '0) begin
        re_q <= 1'b0;
      end else begin
        addr_q <= addr_q + AW'(1);
        rem_q  <= rem_q - LEN_W'(1);
      end
    end
  end

  assign mem_re_o   = re_q;
  assign mem_addr_o = addr_q;
  assign last_o     = re_q && (rem_q == '0);

endmodule

// File: rtl/arr_load_seq.sv
// Byte-serial load sequencer for the 16x16 array controller: sends 4 config
// bytes, the activation and weight streams from SRAM, then holds RUN mode
// until the controller reports done or the run timer expires.
//   clk, rst               : clock, synchronous active-high reset
//   start, cfg_bytes       : sequence request and config bytes (byte0 first)
//   mem_re/mem_addr/mem_rdata : byte SRAM, data one cycle after the read
//   arr_done               : completion from the array controller
//   enable/mode/data_load/data_in : controller load/run interface
//   busy, seq_done, err_timeout : status
module arr_load_seq
  import arr_seq_pkg::*;
#(
  parameter int unsigned ACT_BYTES = DEF_ACT_BYTES,
  parameter int unsigned WGT_BYTES = DEF_WGT_BYTES,
  parameter int unsigned ACT_BASE  = DEF_ACT_BASE,
  parameter int unsigned WGT_BASE  = DEF_WGT_BASE,
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned RUN_MAX   = DEF_RUN_MAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [31:0]   cfg_bytes,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  input  logic          arr_done,
  output logic          enable,
  output logic [1:0]    mode,
  output logic          data_load,
  output logic [7:0]    data_in,
  output logic          busy,
  output logic          seq_done,
  output logic          err_timeout
);

  localparam int unsigned RUN_W = $clog2(RUN_MAX);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [31:0]      cfg_q, cfg_d;
  logic             err_q, err_d;
  logic [1:0]       mode_q, mode_d;
  logic             enable_q, enable_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             rd_load;
  logic [AW-1:0]    rd_base;
  logic [CNT_W-1:0] rd_len;
  logic             rd_last;

  arr_seq_rdgen #(
    .AW    (AW),
    .LEN_W (CNT_W)
  ) u_rdgen (
    .clk        (clk),
    .rst        (rst),
    .load_i     (rd_load),
    .base_i     (rd_base),
    .len_i      (rd_len),
    .mem_re_o   (mem_re),
    .mem_addr_o (mem_addr),
    .last_o     (rd_last)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      run_q    <= '0;
      cfg_q    <= '0;
      err_q    <= 1'b0;
      mode_q   <= MODE_CFG;
      enable_q <= 1'b0;
      load_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      cfg_q    <= cfg_d;
      err_q    <= err_d;
      mode_q   <= mode_d;
      enable_q <= enable_d;
      load_q   <= load_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next state, read-generator control, and output values for the next cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    cfg_d    = cfg_q;
    err_d    = err_q;
    rd_load  = 1'b0;
    rd_base  = AW'(ACT_BASE);
    rd_len   = CNT_W'(ACT_BYTES);
    mode_d   = MODE_CFG;
    enable_d = 1'b0;
    load_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CFG;
          cnt_d   = '0;
          cfg_d   = cfg_bytes;
          err_d   = 1'b0;
        end
      end
      ST_CFG: begin
        // Load at cnt=2 so the first activation read is presented at cnt=3
        if (cnt_q == CNT_W'(2)) rd_load = 1'b1;
        if (cnt_q == CNT_W'(3)) begin
          state_d = ST_ACT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACT: begin
        // Chain the weight burst directly behind the last activation read
        if (rd_last) begin
          rd_load = 1'b1;
          rd_base = AW'(WGT_BASE);
          rd_len  = CNT_W'(WGT_BYTES);
        end
        if (cnt_q == CNT_W'(ACT_BYTES - 1)) begin
          state_d = ST_WGT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WGT: begin
        if (cnt_q == CNT_W'(WGT_BYTES - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          run_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        // Done takes priority over a coincident timeout
        if (arr_done) begin
          state_d = ST_FIN;
        end else if (run_q == RUN_W'(RUN_MAX - 1)) begin
          state_d = ST_FIN;
          err_d   = 1'b1;
        end else begin
          run_d = run_q + RUN_W'(1);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_CFG: begin
        enable_d = 1'b1;
        load_d   = 1'b1;
      end
      ST_ACT: begin
        mode_d   = MODE_ACT;
        enable_d = 1'b1;
        load_d   = 1'b1;
      end
      ST_WGT: begin
        mode_d   = MODE_WGT;
        enable_d = 1'b1;
        load_d   = 1'b1;
      end
      ST_RUN: begin
        mode_d   = MODE_RUN;
        enable_d = 1'b1;
      end
      default: ;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  // Byte lane: config register in CFG, SRAM output register while streaming
  always_comb begin
    data_in = 8'h00;
    case (state_q)
      ST_CFG:         data_in = 8'(cfg_q >> {cnt_q[1:0], 3'b000});
      ST_ACT, ST_WGT: data_in = mem_rdata;
      default:        data_in = 8'h00;
    endcase
  end

  assign mode        = mode_q;
  assign enable      = enable_q;
  assign data_load   = load_q;
  assign busy        = busy_q;
  assign seq_done    = done_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_arr_load_seq.sv
// Self-checking bench for arr_load_seq: SRAM model plus a reference byte
// stream built from the config word and SRAM contents.
module tb_arr_load_seq;

  localparam int unsigned ACT_BYTES = 432;
  localparam int unsigned WGT_BYTES = 768;
  localparam int unsigned ACT_BASE  = 0;
  localparam int unsigned WGT_BASE  = 1024;
  localparam int unsigned AW        = 12;
  localparam int unsigned RUN_MAX   = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   cfg_bytes;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          arr_done;
  logic          enable;
  logic [1:0]    mode;
  logic          data_load;
  logic [7:0]    data_in;
  logic          busy;
  logic          seq_done;
  logic          err_timeout;

  logic [7:0] sram [0:(1<<AW)-1];

  int tests = 0;
  int fails = 0;

  arr_load_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_bytes   (cfg_bytes),
    .mem_re      (mem_re),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .arr_done    (arr_done),
    .enable      (enable),
    .mode        (mode),
    .data_load   (data_load),
    .data_in     (data_in),
    .busy        (busy),
    .seq_done    (seq_done),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM: data valid the cycle after mem_re
  always @(posedge clk) if (mem_re) mem_rdata <= sram[mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_enable"},   32'(enable),      32'd0);
    chk({tag, "_dload"},    32'(data_load),   32'd0);
    chk({tag, "_mem_re"},   32'(mem_re),      32'd0);
    chk({tag, "_busy"},     32'(busy),        32'd0);
    chk({tag, "_seq_done"}, 32'(seq_done),    32'd0);
    chk({tag, "_err"},      32'(err_timeout), 32'd0);
    chk({tag, "_mode"},     32'(mode),        32'd0);
    chk({tag, "_data_in"},  32'(data_in),     32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr),    32'd0);
  endtask

  // One full sequence. done_at: RUN cycle of arr_done (-1 = never).
  // abort_at: stream index at which reset is asserted (-1 = none).
  // poke: drive arr_done during ACT and start during WGT.
  task automatic run_seq(input logic [31:0] cfg, input int done_at,
                         input int abort_at, input bit poke);
    logic [7:0]    exp_q[$];
    logic [AW-1:0] exp_addr;
    logic [1:0]    exp_mode;
    int            reads;
    int            total;

    for (int i = 0; i < 4; i++) exp_q.push_back(8'(cfg >> (8 * i)));
    for (int i = 0; i < int'(ACT_BYTES); i++) exp_q.push_back(sram[AW'(ACT_BASE + i)]);
    for (int i = 0; i < int'(WGT_BYTES); i++) exp_q.push_back(sram[AW'(WGT_BASE + i)]);
    total = exp_q.size();

    start     = 1'b1;
    cfg_bytes = cfg;
    tick();
    start     = 1'b0;
    cfg_bytes = $urandom;
    chk("err_clear", 32'(err_timeout), 32'd0);

    reads = 0;
    for (int n = 0; n < total; n++) begin
      exp_mode = (n < 4) ? 2'b00 : (n < 4 + int'(ACT_BYTES)) ? 2'b01 : 2'b10;
      chk("mode",      32'(mode),      32'(exp_mode));
      chk("data_load", 32'(data_load), 32'd1);
      chk("enable",    32'(enable),    32'd1);
      chk("busy",      32'(busy),      32'd1);
      chk("seq_done",  32'(seq_done),  32'd0);
      chk("data_in",   32'(data_in),   32'(exp_q[n]));
      if (mem_re) begin
        exp_addr = (reads < int'(ACT_BYTES)) ? AW'(ACT_BASE + reads)
                                             : AW'(WGT_BASE + reads - ACT_BYTES);
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        reads++;
      end
      if (n == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("abort");
        return;
      end
      arr_done = poke && (n >= 8) && (n < 40);
      start    = poke && (n >= 600) && (n < 604);
      tick();
    end
    arr_done = 1'b0;
    start    = 1'b0;
    chk("read_count", 32'(reads), 32'(ACT_BYTES + WGT_BYTES));

    for (int r = 0; r < int'(RUN_MAX); r++) begin
      chk("run_mode",   32'(mode),      32'd3);
      chk("run_dload",  32'(data_load), 32'd0);
      chk("run_din",    32'(data_in),   32'd0);
      chk("run_mem_re", 32'(mem_re),    32'd0);
      chk("run_done",   32'(seq_done),  32'd0);
      if (r == done_at) begin
        arr_done = 1'b1;
        tick();
        arr_done = 1'b0;
        break;
      end
      tick();
    end

    chk("fin_done",   32'(seq_done),    32'd1);
    chk("fin_enable", 32'(enable),      32'd0);
    chk("fin_mode",   32'(mode),        32'd0);
    chk("fin_busy",   32'(busy),        32'd1);
    chk("fin_err",    32'(err_timeout), (done_at < 0) ? 32'd1 : 32'd0);
    tick();
    chk("idle_done",  32'(seq_done),    32'd0);
    chk("idle_busy",  32'(busy),        32'd0);
    chk("idle_err",   32'(err_timeout), (done_at < 0) ? 32'd1 : 32'd0);

    // arr_done while idle must not wake the sequencer
    arr_done = 1'b1;
    tick();
    arr_done = 1'b0;
    tick();
    chk("idle_done_ignored", 32'(busy), 32'd0);
    chk("idle_err_sticky",   32'(err_timeout), (done_at < 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    arr_done  = 1'b0;
    cfg_bytes = '0;
    for (int i = 0; i < (1 << AW); i++) sram[i] = 8'(i);
    tick();
    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    // Directed config word, address-pattern SRAM, done after 100 RUN cycles
    run_seq(32'h1010_0310, 100, -1, 1'b0);

    // Random SRAM contents from here on
    for (int i = 0; i < (1 << AW); i++) sram[i] = 8'($urandom_range(0, 255));

    // Stray arr_done in ACT and start in WGT must not disturb the stream
    run_seq($urandom, int'($urandom_range(0, 300)), -1, 1'b1);

    // Timeout: exactly RUN_MAX cycles of RUN mode, error set
    run_seq($urandom, -1, -1, 1'b0);

    // Next start clears the error; abort with reset at activation byte 200
    run_seq($urandom, 5, 4 + 200, 1'b0);

    // Replay after abort, done coinciding with the timeout cycle
    run_seq(32'hA1B2_C3D4, int'(RUN_MAX) - 1, -1, 1'b0);

    // Done on the very first RUN cycle
    run_seq($urandom, 0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
